axi4lite_reg_responder: RTL and testbench

AXI4-Lite responder (subordinate) that terminates an AXI4-Lite bus and converts each transaction into a single-cycle request on a simple register port, returning the `PkgAxiLite::resp_t` codes OKAY, SLVERR or DECERR. It sits at the leaf of an AXI4-Lite interconnect, in front of register banks that expose the request/acknowledge register port. It processes one transaction at a time.

---
 rtl/axi4lite_reg_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi4lite_reg_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite subordinate that turns each bus transaction into a one-cycle request/ack on a register port.
// Latency: request one cycle after selection, response valid the cycle after ack, timeout or decode miss.
// Backpressure: one transaction in flight; AW/W/AR readies drop outside IDLE; B/R are held until ready.
// Optional feature macro: AXIL_RESP_TIMEOUT_EN (compiles in the 16-bit WAIT timeout counter).

package PkgAxiLite;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
endpackage

module axi4lite_reg_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WINDOW_SIZE = 4096,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output PkgAxiLite::resp_t     s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output PkgAxiLite::resp_t     s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  reg_wr_req,
  output logic                  reg_rd_req,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [DATA_W-1:0]     reg_wr_data,
  output logic [DATA_W/8-1:0]   reg_wr_strb,
  input  logic                  reg_ack,
  input  logic                  reg_err,
  input  logic [DATA_W-1:0]     reg_rd_data
);
  import PkgAxiLite::*;

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] RD_RESP = 3'd5;

  localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WINDOW_SIZE - 1);
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  // Elaboration-time parameter legality
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axi4lite_reg_responder: DATA_W must be 32 or 64");
  end
  if ((WINDOW_SIZE & (WINDOW_SIZE - 1)) != 0) begin : g_bad_window
    $error("axi4lite_reg_responder: WINDOW_SIZE must be a power of two");
  end
  if ((BASE_ADDR & (WINDOW_SIZE - 1)) != 0) begin : g_bad_base
    $error("axi4lite_reg_responder: BASE_ADDR must be aligned to WINDOW_SIZE");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axi4lite_reg_responder: TIMEOUT must be in 2..65535");
  end

  logic [2:0]        state;
  logic              live;       // low during and on the edge of reset so readies come up cleanly
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              cur_wr;     // direction of the transaction in flight
  logic              rd_pri;     // read wins the next write/read collision

  logic              idle;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_full;
  logic              sel_wr;
  logic              sel_rd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_hit;
  logic              tmo_hit;

  assign idle      = live && (state == IDLE);
  assign s_awready = idle && !aw_held;
  assign s_wready  = idle && !w_held;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  // A write is complete once both halves are held or arriving this cycle
  assign wr_full   = (aw_held || aw_hs) && (w_held || w_hs);
  // AR is refused only while a complete write holds the arbitration win
  assign s_arready = idle && (!wr_full || rd_pri);
  assign ar_hs     = s_arvalid && s_arready;
  assign sel_rd    = ar_hs;
  assign sel_wr    = wr_full && !ar_hs;

  assign wr_addr   = aw_held ? aw_addr_q : s_awaddr;
  assign wr_data   = w_held ? w_data_q : s_wdata;
  assign wr_strb   = w_held ? w_strb_q : s_wstrb;
  assign sel_addr  = sel_rd ? s_araddr : wr_addr;
  assign sel_hit   = (sel_addr & ~WIN_MASK) == BASE;

  assign s_bvalid   = (state == WR_RESP);
  assign s_rvalid   = (state == RD_RESP);
  assign reg_wr_req = (state == WR_REQ);
  assign reg_rd_req = (state == RD_REQ);

`ifdef AXIL_RESP_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count WAIT cycles; held at zero elsewhere so every wait starts from a clean count
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM: capture, select/decode, request, wait for ack, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      live        <= 1'b0;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      cur_wr      <= 1'b0;
      rd_pri      <= 1'b0;
      s_bresp     <= OKAY;
      s_rresp     <= OKAY;
      s_rdata     <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_wdata;
            w_strb_q <= s_wstrb;
          end
          // Pointer moves only on a real collision, so an uncontested grant keeps fairness intact
          if (wr_full && s_arvalid) begin
            rd_pri <= !rd_pri;
          end
          if (sel_rd) begin
            cur_wr <= 1'b0;
            if (sel_hit) begin
              reg_addr <= sel_addr & WIN_MASK & ~LSB_MASK;
              state    <= RD_REQ;
            end else begin
              s_rresp <= DECERR;
              s_rdata <= '0;
              state   <= RD_RESP;
            end
          end else if (sel_wr) begin
            cur_wr <= 1'b1;
            if (sel_hit) begin
              reg_addr    <= sel_addr & WIN_MASK & ~LSB_MASK;
              reg_wr_data <= wr_data;
              reg_wr_strb <= wr_strb;
              state       <= WR_REQ;
            end else begin
              s_bresp <= DECERR;
              state   <= WR_RESP;
            end
          end
        end
        WR_REQ: state <= WAIT;
        RD_REQ: state <= WAIT;
        WAIT: begin
          if (reg_ack) begin
            if (cur_wr) begin
              s_bresp <= reg_err ? SLVERR : OKAY;
              state   <= WR_RESP;
            end else begin
              s_rresp <= reg_err ? SLVERR : OKAY;
              s_rdata <= reg_err ? '0 : reg_rd_data;
              state   <= RD_RESP;
            end
          end else if (tmo_hit) begin
            if (cur_wr) begin
              s_bresp <= SLVERR;
              state   <= WR_RESP;
            end else begin
              s_rresp <= SLVERR;
              s_rdata <= '0;
              state   <= RD_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Directed bench for axi4lite_reg_responder with a response scoreboard and a simple register-bank model.
// Latency: checks request, response, decode-miss and timeout cycle positions.
// Backpressure: exercises split AW/W arrival, held-off bready and write/read collisions.

module tb_axi4lite_reg_responder;
  localparam int TMO = 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        reg_wr_req;
  logic        reg_rd_req;
  logic [31:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_b = 0;
  int n_r = 0;
  int wr_req_cnt = 0;
  int rd_req_cnt = 0;

  int          bank_delay = 1;
  logic        bank_err = 1'b0;
  logic [31:0] bank_rdata = '0;
  int          req_cyc = -1;
  logic [31:0] rec_addr = '0;
  logic [31:0] rec_wdata = '0;
  logic [3:0]  rec_strb = '0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  bit          order_q[$];
  logic [1:0]  b_exp;
  logic [33:0] r_exp;

  axi4lite_reg_responder #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(0), .WINDOW_SIZE(4096), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_wr_req(reg_wr_req), .reg_rd_req(reg_rd_req), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  // Cycle index and request-pulse counters
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    wr_req_cnt <= wr_req_cnt + (reg_wr_req ? 1 : 0);
    rd_req_cnt <= rd_req_cnt + (reg_rd_req ? 1 : 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare at every B/R handshake, and log completion order
  always @(negedge clk) begin
    if (s_bvalid && s_bready) begin
      n_b++;
      order_q.push_back(1'b1);
      check("b_sb_nonempty", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        b_exp = exp_b.pop_front();
        check("bresp", s_bresp, b_exp);
      end
    end
    if (s_rvalid && s_rready) begin
      n_r++;
      order_q.push_back(1'b0);
      check("r_sb_nonempty", exp_r.size() != 0, 1);
      if (exp_r.size() != 0) begin
        r_exp = exp_r.pop_front();
        check("rresp", s_rresp, r_exp[33:32]);
        check("rdata", s_rdata, r_exp[31:0]);
      end
    end
  end

  // Register-bank model: records each request and acks bank_delay cycles later (never if <= 0)
  initial begin : bank
    reg_ack = 1'b0;
    reg_err = 1'b0;
    reg_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (reg_wr_req || reg_rd_req) begin
        req_cyc   = cyc;
        rec_addr  = reg_addr;
        rec_wdata = reg_wr_data;
        rec_strb  = reg_wr_strb;
        if (bank_delay > 0) begin
          repeat (bank_delay) @(posedge clk);
          #1;
          reg_ack = 1'b1;
          reg_err = bank_err;
          reg_rd_data = bank_rdata;
          @(posedge clk); #1;
          reg_ack = 1'b0;
          reg_err = 1'b0;
          reg_rd_data = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present any mix of AW/W/AR and hold each until it handshakes; hs_cyc is the last handshake cycle
  task automatic xact(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [31:0] aaddr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] raddr, output int hs_cyc);
    bit aw_p, w_p, ar_p, aw_h, w_h, ar_h;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar;
    s_awvalid = do_aw; s_awaddr = aaddr;
    s_wvalid = do_w; s_wdata = wdata; s_wstrb = strb;
    s_arvalid = do_ar; s_araddr = raddr;
    hs_cyc = -1;
    for (int i = 0; i < 200 && (aw_p || w_p || ar_p); i++) begin
      @(negedge clk);
      aw_h = aw_p && s_awready;
      w_h  = w_p && s_wready;
      ar_h = ar_p && s_arready;
      if (aw_h || w_h || ar_h) hs_cyc = cyc;
      @(posedge clk); #1;
      if (aw_h) begin aw_p = 1'b0; s_awvalid = 1'b0; end
      if (w_h)  begin w_p = 1'b0;  s_wvalid = 1'b0;  end
      if (ar_h) begin ar_p = 1'b0; s_arvalid = 1'b0; end
    end
    check("handshakes_done", {aw_p, w_p, ar_p}, 0);
  endtask

  task automatic wait_bvalid(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_bvalid) begin c = cyc; break; end
    end
    check("bvalid_seen", c >= 0, 1);
  endtask

  task automatic wait_rvalid(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_rvalid) begin c = cyc; break; end
    end
    check("rvalid_seen", c >= 0, 1);
  endtask

  // Complete write and AR in the same cycle; returns which direction finished first and second
  task automatic run_pair(input logic [31:0] wa, input logic [31:0] ra, input logic [31:0] rd,
                          output bit o0, output bit o1);
    int hs;
    int done0;
    done0 = n_b + n_r;
    order_q.delete();
    bank_delay = 1; bank_err = 1'b0; bank_rdata = rd;
    exp_b.push_back(RESP_OKAY);
    exp_r.push_back({RESP_OKAY, rd});
    xact(1, 1, 1, wa, 32'hA5A50000 ^ wa, 4'hF, ra, hs);
    for (int i = 0; i < 200 && (n_b + n_r - done0) < 2; i++) @(posedge clk);
    #1;
    check("pair_done", n_b + n_r - done0, 2);
    o0 = (order_q.size() > 0) ? order_q[0] : 1'b0;
    o1 = (order_q.size() > 1) ? order_q[1] : 1'b0;
  endtask

  initial begin : main
    int hs, bc, rc, wc0, rc0, nb0;
    bit f0, f1;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_readies", {s_awready, s_wready, s_arready}, 0);
    check("rst_valids", {s_bvalid, s_rvalid}, 0);
    check("rst_reqs", {reg_wr_req, reg_rd_req}, 0);
    check("rst_resps", {s_bresp, s_rresp}, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_payload", {reg_addr, reg_wr_data, reg_wr_strb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    @(negedge clk);
    check("readies_after_rst", {s_awready, s_wready, s_arready}, 3'b111);
    step();

    // Best-case write, ack 3 cycles after the request
    bank_delay = 3; bank_err = 1'b0;
    exp_b.push_back(RESP_OKAY);
    wc0 = wr_req_cnt;
    xact(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, hs);
    wait_bvalid(bc);
    check("wr_req_lat", req_cyc, hs + 1);
    check("wr_req_pulses", wr_req_cnt - wc0, 1);
    check("wr_addr", rec_addr, 32'h10);
    check("wr_data", rec_wdata, 32'hDEADBEEF);
    check("wr_strb", rec_strb, 4'hF);
    check("b_lat", bc, req_cyc + 4);
    repeat (2) step();

    // Read with data, then the same read with an error from the bank
    bank_delay = 2; bank_rdata = 32'h12345678;
    exp_r.push_back({RESP_OKAY, 32'h12345678});
    rc0 = rd_req_cnt;
    xact(0, 0, 1, 0, 0, 0, 32'h14, hs);
    wait_rvalid(rc);
    check("rd_req_lat", req_cyc, hs + 1);
    check("rd_addr", rec_addr, 32'h14);
    check("r_lat", rc, req_cyc + 3);
    repeat (2) step();
    bank_err = 1'b1;
    exp_r.push_back({RESP_SLVERR, 32'h0});
    xact(0, 0, 1, 0, 0, 0, 32'h14, hs);
    wait_rvalid(rc);
    check("rd_req_pulses", rd_req_cnt - rc0, 2);
    repeat (2) step();
    bank_err = 1'b0;

    // Decode misses: no register request, response the cycle after selection
    rc0 = rd_req_cnt;
    exp_r.push_back({RESP_DECERR, 32'h0});
    xact(0, 0, 1, 0, 0, 0, 32'h1000, hs);
    wait_rvalid(rc);
    check("rd_miss_lat", rc, hs + 1);
    check("rd_miss_no_req", rd_req_cnt - rc0, 0);
    repeat (2) step();
    wc0 = wr_req_cnt;
    exp_b.push_back(RESP_DECERR);
    xact(1, 1, 0, 32'h2004, 32'h1, 4'h1, 0, hs);
    wait_bvalid(bc);
    check("wr_miss_lat", bc, hs + 1);
    check("wr_miss_no_req", wr_req_cnt - wc0, 0);
    repeat (2) step();

    // W arrives 5 cycles before AW, all-zero strobe, bready held off for 10 cycles
    s_bready = 1'b0;
    bank_delay = 2;
    exp_b.push_back(RESP_OKAY);
    wc0 = wr_req_cnt;
    nb0 = n_b;
    xact(0, 1, 0, 0, 32'h0BADF00D, 4'h0, 0, hs);
    repeat (5) step();
    @(negedge clk);
    check("w_only_no_req", wr_req_cnt - wc0, 0);
    check("w_held_blocks_w", s_wready, 0);
    check("w_held_aw_open", s_awready, 1);
    @(posedge clk); #1;
    xact(1, 0, 0, 32'h18, 0, 0, 0, hs);
    wait_bvalid(bc);
    check("split_req_lat", req_cyc, hs + 1);
    check("split_addr", rec_addr, 32'h18);
    check("split_data", rec_wdata, 32'h0BADF00D);
    check("split_zero_strb", rec_strb, 4'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("b_stall_stable", {s_bvalid, s_bresp}, {1'b1, RESP_OKAY});
    end
    @(posedge clk); #1;
    s_bready = 1'b1;
    for (int i = 0; i < 20 && n_b == nb0; i++) step();
    check("split_b_done", n_b - nb0, 1);
    check("split_single_req", wr_req_cnt - wc0, 1);
    repeat (2) step();

    // Collisions: write wins after reset, then read, then write again
    run_pair(32'h40, 32'h44, 32'hCAFE0001, f0, f1);
    check("pair1_order", {f0, f1}, 2'b10);
    repeat (2) step();
    run_pair(32'h48, 32'h4C, 32'hCAFE0002, f0, f1);
    check("pair2_order", {f0, f1}, 2'b01);
    repeat (2) step();
    run_pair(32'h50, 32'h54, 32'hCAFE0003, f0, f1);
    check("pair3_order", {f0, f1}, 2'b10);
    repeat (2) step();

`ifdef AXIL_RESP_TIMEOUT_EN
    // No ack within TIMEOUT: SLVERR, and the late ack is ignored
    bank_delay = 12;
    exp_b.push_back(RESP_SLVERR);
    xact(1, 1, 0, 32'h20, 32'h1, 4'hF, 0, hs);
    wait_bvalid(bc);
    check("tmo_lat", bc, req_cyc + TMO + 1);
    nb0 = n_b + 1;
    repeat (16) step();
    check("late_ack_no_resp", n_b, nb0);
    check("late_ack_idle", s_awready, 1);
`endif

    // Reset during WAIT: nothing answered, everything back to reset values
    bank_delay = 0;
    nb0 = n_b;
    xact(1, 1, 0, 32'h30, 32'h77, 4'h3, 0, hs);
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst_readies", {s_awready, s_wready, s_arready}, 0);
    check("midrst_valids", {s_bvalid, s_rvalid, reg_wr_req, reg_rd_req}, 0);
    check("midrst_resps", {s_bresp, s_rresp}, 0);
    check("midrst_payload", {reg_addr, reg_wr_data, reg_wr_strb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) step();
    check("midrst_dropped", n_b - nb0, 0);
    check("midrst_readies_back", {s_awready, s_wready, s_arready}, 3'b111);

    // Arbitration pointer returns to write-first after reset
    run_pair(32'h60, 32'h64, 32'hCAFE0004, f0, f1);
    check("pair4_order", {f0, f1}, 2'b10);
    repeat (2) step();
    check("sb_drained", exp_b.size() + exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop in case a bounded wait is ever bypassed
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
